// File: rtl/bcd_pkg.sv
// -----------------------------------------------------------------------------
// bcd_pkg
//
// Shared BCD definitions for the multi-digit counter and its digit cell.
//
//   bcd_digit_t   : one packed BCD digit (4 bits)
//   BCD_MAX       : largest legal digit value (9)
//   BCD_MIN       : smallest legal digit value (0)
//   bcd_valid()   : 1 when a nibble holds a legal BCD digit (0-9)
//   bcd_clean()   : returns the nibble unchanged when legal, BCD_MIN otherwise
//
// Configuration macro used by the files that import this package:
//   BCD_COUNTER_DOWN_EN - when defined, the counter honours the up input and
//                         can count down; when undefined it is up-only.
// -----------------------------------------------------------------------------
package bcd_pkg;

    typedef logic [3:0] bcd_digit_t;

    localparam bcd_digit_t BCD_MAX = 4'd9;
    localparam bcd_digit_t BCD_MIN = 4'd0;

    // Legal BCD digits are 0..9; codes 10..15 are never allowed in count.
    function automatic logic bcd_valid(input bcd_digit_t digit);
        return (digit <= BCD_MAX);
    endfunction

    // Illegal load nibbles are forced to zero so count can never hold a
    // non-BCD digit, whatever arrives on load_val.
    function automatic bcd_digit_t bcd_clean(input bcd_digit_t digit);
        return bcd_valid(digit) ? digit : BCD_MIN;
    endfunction

endpackage : bcd_pkg

// File: rtl/bcd_digit.sv
// -----------------------------------------------------------------------------
// bcd_digit
//
// One BCD digit register of the cascaded counter. The digit advances by one
// (up) or retreats by one (down) on a clock edge where step_in is high, and
// reports through step_out that the step ripples into the next digit.
//
// Ports:
//   clk        in   clock, all state updates on its rising edge
//   reset      in   synchronous active-high reset, clears the digit to 0
//   load       in   parallel load strobe (beats stepping)
//   load_digit in   raw load nibble; illegal codes 10..15 are loaded as 0
//   step_in    in   carry (up) or borrow (down) into this digit
//   up         in   direction: 1 = increment, 0 = decrement
//   digit      out  registered digit value, always 0..9
//   step_out   out  carry/borrow out: step_in AND digit at its wrap value
//   at_max     out  digit currently holds 9
//   at_min     out  digit currently holds 0
//
// Configuration: BCD_COUNTER_DOWN_EN. When undefined the cell is
// increment-only, up is ignored and no decrement path exists.
// -----------------------------------------------------------------------------
module bcd_digit
    import bcd_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       load,
    input  bcd_digit_t load_digit,
    input  logic       step_in,
    input  logic       up,
    output bcd_digit_t digit,
    output logic       step_out,
    output logic       at_max,
    output logic       at_min
);

    bcd_digit_t digit_q;
    bcd_digit_t digit_next;

    assign digit  = digit_q;
    assign at_max = (digit_q == BCD_MAX);
    assign at_min = (digit_q == BCD_MIN);

`ifdef BCD_COUNTER_DOWN_EN
    // Value after one step in the selected direction, wrapping 9->0 going up
    // and 0->9 going down.
    always_comb begin
        digit_next = digit_q;
        if (up) begin
            digit_next = at_max ? BCD_MIN : digit_q + 4'd1;
        end else begin
            digit_next = at_min ? BCD_MAX : digit_q - 4'd1;
        end
    end

    // The step only ripples onward when this digit is about to wrap.
    assign step_out = step_in & (up ? at_max : at_min);
`else
    // Increment-only build: direction input is kept on the port but unused.
    logic unused_up;
    assign unused_up = up;

    always_comb begin
        digit_next = at_max ? BCD_MIN : digit_q + 4'd1;
    end

    assign step_out = step_in & at_max;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            digit_q <= BCD_MIN;
        end else if (load) begin
            digit_q <= bcd_clean(load_digit);
        end else if (step_in) begin
            digit_q <= digit_next;
        end
    end

endmodule : bcd_digit

// File: rtl/bcd_counter_n.sv
// -----------------------------------------------------------------------------
// bcd_counter_n
//
// Parametrised multi-digit synchronous BCD counter built from DIGITS chained
// bcd_digit cells. Supports count enable, parallel load with digit
// validation, up/down direction, a combinational terminal-count flag and
// registered one-cycle wrap / load-error pulses.
//
// Edge priority: reset > load > en > hold.
//
// Parameters:
//   DIGITS     number of BCD digits, legal range 1..8 (count is 4*DIGITS wide)
//
// Ports:
//   clk        in   clock, all state updates on its rising edge
//   reset      in   synchronous active-high reset
//   en         in   count enable, one step per clock while high
//   load       in   parallel load strobe (en is ignored on a load edge)
//   up         in   direction, 1 = up, 0 = down (ignored in up-only build)
//   load_val   in   packed BCD load value, digit 0 in [3:0]
//   count      out  registered packed BCD count
//   tc         out  combinational terminal count: the next enabled edge wraps
//   wrap       out  registered pulse, high the cycle after a wrap edge
//   load_err   out  registered pulse, high the cycle after a load that held
//                   at least one nibble of 10..15
//
// Configuration: BCD_COUNTER_DOWN_EN. When undefined the counter is up-only,
// up is ignored, tc = en AND all digits 9, and no decrement logic exists.
// -----------------------------------------------------------------------------
module bcd_counter_n
    import bcd_pkg::*;
#(
    parameter int DIGITS = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  en,
    input  logic                  load,
    input  logic                  up,
    input  logic [4*DIGITS-1:0]   load_val,
    output logic [4*DIGITS-1:0]   count,
    output logic                  tc,
    output logic                  wrap,
    output logic                  load_err
);

    // step[k] is the carry/borrow into digit k; step[DIGITS] leaves the top
    // digit and therefore marks an edge on which the whole counter wraps.
    logic [DIGITS:0]   step;
    logic [DIGITS-1:0] at_max;
    logic [DIGITS-1:0] at_min;
    logic [DIGITS-1:0] bad_nibble;
    logic              all_max;
    logic              all_min;
    logic              dir_up;

    assign step[0] = en;

    // The chain is one AND level per digit, at most eight levels for the
    // widest counter, so a plain ripple is kept instead of a lookahead tree.
    for (genvar g = 0; g < DIGITS; g++) begin : g_digit
        bcd_digit u_digit (
            .clk        (clk),
            .reset      (reset),
            .load       (load),
            .load_digit (load_val[4*g +: 4]),
            .step_in    (step[g]),
            .up         (up),
            .digit      (count[4*g +: 4]),
            .step_out   (step[g+1]),
            .at_max     (at_max[g]),
            .at_min     (at_min[g])
        );

        assign bad_nibble[g] = !bcd_valid(load_val[4*g +: 4]);
    end

    assign all_max = &at_max;
    assign all_min = &at_min;

`ifdef BCD_COUNTER_DOWN_EN
    assign dir_up = up;
`else
    // Up-only build: the all-zero detect has no consumer.
    logic unused_all_min;
    assign unused_all_min = all_min;
    assign dir_up = 1'b1;
`endif

    // Terminal count looks only at count, en and up; it is independent of
    // load so that it reflects what an enabled step would do.
    assign tc = en & (dir_up ? all_max : all_min);

    always_ff @(posedge clk) begin
        if (reset) begin
            wrap     <= 1'b0;
            load_err <= 1'b0;
        end else begin
            // A load edge never steps, so it can never wrap.
            wrap     <= !load & step[DIGITS];
            load_err <= load & (|bad_nibble);
        end
    end

endmodule : bcd_counter_n

// File: tb/tb_bcd_counter_n.sv
// -----------------------------------------------------------------------------
// tb_bcd_counter_n
//
// Drives a 2-digit and a 4-digit counter with the same control inputs (the
// 2-digit one sees the low byte of the load value) and compares both against
// a decimal-arithmetic reference model: the count is held as an integer and
// stepped modulo 10^DIGITS, then converted back to packed BCD.
// -----------------------------------------------------------------------------
module tb_bcd_counter_n;

`ifdef BCD_COUNTER_DOWN_EN
    localparam bit DOWN_EN = 1'b1;
`else
    localparam bit DOWN_EN = 1'b0;
`endif

    localparam int W = 28;  // {wrap_b, err_b, count_b[15:0], wrap_a, err_a, count_a[7:0]}

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset = 1'b1;
    logic        en    = 1'b0;
    logic        load  = 1'b0;
    logic        up    = 1'b1;
    logic [15:0] lv    = 16'h0;

    logic [7:0]  count_a;
    logic        tc_a, wrap_a, err_a;
    logic [15:0] count_b;
    logic        tc_b, wrap_b, err_b;

    bcd_counter_n #(.DIGITS(2)) dut_a (
        .clk      (clk),
        .reset    (reset),
        .en       (en),
        .load     (load),
        .up       (up),
        .load_val (lv[7:0]),
        .count    (count_a),
        .tc       (tc_a),
        .wrap     (wrap_a),
        .load_err (err_a)
    );

    bcd_counter_n #(.DIGITS(4)) dut_b (
        .clk      (clk),
        .reset    (reset),
        .en       (en),
        .load     (load),
        .up       (up),
        .load_val (lv),
        .count    (count_b),
        .tc       (tc_b),
        .wrap     (wrap_b),
        .load_err (err_b)
    );

    // ---------------- checking ----------------
    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    int m_a = 0, m_b = 0;
    bit mw_a = 0, me_a = 0, mw_b = 0, me_b = 0;
    bit model_valid = 0;
    logic [W-1:0] exp_q[$];

    function automatic int pow10(input int n);
        int p = 1;
        for (int i = 0; i < n; i++) p = p * 10;
        return p;
    endfunction

    // Decimal value of a load word; illegal nibbles read as zero.
    function automatic int load_to_int(input logic [31:0] b, input int n, output bit bad);
        int v = 0;
        int p = 1;
        logic [3:0] nib;
        bad = 0;
        for (int i = 0; i < n; i++) begin
            nib = b[4*i +: 4];
            if (nib > 4'd9) begin
                bad = 1;
                nib = 4'd0;
            end
            v = v + int'(nib) * p;
            p = p * 10;
        end
        return v;
    endfunction

    function automatic logic [31:0] to_bcd(input int v, input int n);
        logic [31:0] r = '0;
        int x = v;
        for (int i = 0; i < n; i++) begin
            r[4*i +: 4] = 4'(x % 10);
            x = x / 10;
        end
        return r;
    endfunction

    function automatic bit model_tc(input int n, input int val, input bit e, input bit u);
        bit go_up = !DOWN_EN || u;
        return e && (go_up ? (val == pow10(n) - 1) : (val == 0));
    endfunction

    task automatic model_step(input int n, inout int val, inout bit w, inout bit er,
                              input bit r, input bit ld, input bit e, input bit u,
                              input logic [31:0] v);
        int modv = pow10(n);
        bit bad;
        if (r) begin
            val = 0; w = 0; er = 0;
        end else if (ld) begin
            val = load_to_int(v, n, bad);
            er  = bad;
            w   = 0;
        end else begin
            er = 0;
            if (e && (!DOWN_EN || u)) begin
                w   = (val == modv - 1);
                val = (val + 1) % modv;
            end else if (e) begin
                w   = (val == 0);
                val = (val + modv - 1) % modv;
            end else begin
                w = 0;
            end
        end
    endtask

    // ---------------- driver ----------------
    task automatic cycle(input bit r, input bit ld, input bit e, input bit u, input logic [15:0] v);
        logic [31:0] ba, bb;
        logic [W-1:0] exp_w, got_w;
        @(negedge clk);
        reset = r; load = ld; en = e; up = u; lv = v;
        #1;
        if (model_valid) begin
            check("tc_a", 32'(tc_a), 32'(model_tc(2, m_a, e, u)));
            check("tc_b", 32'(tc_b), 32'(model_tc(4, m_b, e, u)));
        end
        model_step(2, m_a, mw_a, me_a, r, ld, e, u, {16'h0, v});
        model_step(4, m_b, mw_b, me_b, r, ld, e, u, {16'h0, v});
        if (r) model_valid = 1;
        ba = to_bcd(m_a, 2);
        bb = to_bcd(m_b, 4);
        exp_q.push_back({mw_b, me_b, bb[15:0], mw_a, me_a, ba[7:0]});
        @(posedge clk);
        #1;
        exp_w = exp_q.pop_front();
        got_w = {wrap_b, err_b, count_b, wrap_a, err_a, count_a};
        if (model_valid) begin
            check("count_a",    32'(got_w[7:0]),   32'(exp_w[7:0]));
            check("load_err_a", 32'(got_w[8]),     32'(exp_w[8]));
            check("wrap_a",     32'(got_w[9]),     32'(exp_w[9]));
            check("count_b",    32'(got_w[25:10]), 32'(exp_w[25:10]));
            check("load_err_b", 32'(got_w[26]),    32'(exp_w[26]));
            check("wrap_b",     32'(got_w[27]),    32'(exp_w[27]));
        end
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [15:0] rv;
        int sel;

        // Reset with en high.
        cycle(1, 0, 1, 1, 16'h0000);

        // Up wrap on the 2-digit counter (4-digit one goes 0098 -> 0100).
        cycle(0, 1, 0, 1, 16'h0098);
        cycle(0, 0, 1, 1, 16'h0000);
        cycle(0, 0, 1, 1, 16'h0000);
        cycle(0, 0, 0, 1, 16'h0000);

        // Down wrap (up-only build keeps counting up).
        cycle(0, 1, 0, 0, 16'h0001);
        cycle(0, 0, 1, 0, 16'h0000);
        cycle(0, 0, 1, 0, 16'h0000);
        cycle(0, 0, 0, 0, 16'h0000);

        // Invalid and valid loads.
        cycle(0, 1, 0, 1, 16'h005C);
        cycle(0, 1, 0, 1, 16'h0047);
        cycle(0, 1, 0, 1, 16'hA3F9);

        // Priority: load over en, reset over load.
        cycle(0, 1, 1, 1, 16'h0023);
        cycle(1, 1, 1, 1, 16'h0055);

        // Full-width ripple and 4-digit wrap.
        cycle(0, 1, 0, 1, 16'h0999);
        cycle(0, 0, 1, 1, 16'h0000);
        cycle(0, 1, 0, 1, 16'h9999);
        cycle(0, 0, 1, 1, 16'h0000);
        cycle(0, 0, 1, 0, 16'h0000);

        // Mid-count reset clears pending pulses.
        cycle(0, 1, 0, 1, 16'h9999);
        cycle(0, 0, 1, 1, 16'h0000);
        cycle(1, 0, 1, 1, 16'h0000);

        // Randomised traffic, biased towards the wrap boundaries.
        for (int i = 0; i < 400; i++) begin
            sel = $urandom_range(0, 3);
            case (sel)
                0:       rv = 16'h9999;
                1:       rv = 16'h0000;
                2:       rv = 16'h9998;
                default: rv = 16'($urandom);
            endcase
            cycle($urandom_range(0, 49) == 0,
                  $urandom_range(0, 7) == 0,
                  $urandom_range(0, 3) != 0,
                  1'($urandom_range(0, 1)),
                  rv);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    // Absolute time bound so the run always ends.
    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, %0d/%0d", n_pass, n_checks);
        $fatal(1);
    end

endmodule : tb_bcd_counter_n
